// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one combinational alu with a registered, ID-tagged response stage

// Shared combinational ALU; shifts use the full b value, so amounts >= WIDTH
// naturally yield 0 (sll/srl) or all sign bits (sra).
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    // Operation select and zero flag
    always_comb begin
        case (control)
            3'b000:  result = a + b;
            3'b001:  result = a - b;
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = a << b;
            3'b110:  result = a >> b;
            default: result = $unsigned($signed(a) >>> b);
        endcase
        zero = (result == '0);
    end
endmodule

module alu_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic [15:0]           ops_done
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             can_issue;
    logic             accept;
    int               idx;
    logic [WIDTH-1:0] alu_y;
    logic             alu_z;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
        can_issue = rst_n && (state == EMPTY || rsp_ready);
        accept    = found && can_issue;
        req_ready = accept ? (NREQ'(1) << winner) : '0;
        rsp_valid = (state == FULL);
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a       (req_a[int'(winner)*WIDTH +: WIDTH]),
        .b       (req_b[int'(winner)*WIDTH +: WIDTH]),
        .control (req_op[int'(winner)*3 +: 3]),
        .result  (alu_y),
        .zero    (alu_z)
    );

    // Response register, grant pointer and consumed-response counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            ops_done   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            if (state == FULL && rsp_ready)
                ops_done <= ops_done + 16'd1;
            if (accept) begin
                state      <= FULL;
                rsp_id     <= winner;
                rsp_result <= alu_y;
                rsp_zero   <= alu_z;
                last_grant <= winner;
            end else if (rsp_ready) begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and randomized checks against a behavioural model
module tb_alu_rr_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic [N*3-1:0]  req_op = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_result;
    logic            rsp_zero;
    logic [15:0]     ops_done;

    int n_chk = 0;
    int n_pass = 0;

    // Model state
    bit        m_valid;
    int        m_id;
    logic [31:0] m_result;
    bit        m_zero;
    int        m_ops;
    int        m_last;

    alu_rr_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (b >= 32) ? 32'd0 : a << b[4:0];
            3'd6: return (b >= 32) ? 32'd0 : a >> b[4:0];
            default: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_ops = 0; m_last = N - 1;
    endtask

    // Called just after a falling edge with inputs already applied; ends at the next falling edge
    task automatic step();
        int g;
        bit can;
        logic [31:0] r;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++)
            if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
        can = !m_valid || rsp_ready;
        check("req_ready", 64'(req_ready), (g >= 0 && can) ? 64'(1 << g) : 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("ops_done", 64'(ops_done), 64'(m_ops % 65536));
        if (m_valid) begin
            check("rsp_id", 64'(rsp_id), 64'(m_id));
            check("rsp_result", 64'(rsp_result), 64'(m_result));
            check("rsp_zero", 64'(rsp_zero), 64'(m_zero));
        end
        @(posedge clk);
        if (m_valid && rsp_ready) m_ops++;
        if (g >= 0 && can) begin
            r = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_op[g*3 +: 3]);
            m_valid = 1; m_id = g; m_result = r; m_zero = (r == 0); m_last = g;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ops_done", 64'(ops_done), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Simple add and sub producing zero
        rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd3, 3'd0); req_valid = 4'b0001; step();
        set_req(2, 32'd7, 32'd7, 3'd1); req_valid = 4'b0100; step();
        req_valid = 4'b0000; step(); step();

        // All requesters busy: strict rotation, one grant per cycle
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 10), 32'(i + 1), 3'(i));
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = 4'b0000; step();

        // Backpressure: response held while req1 waits
        set_req(0, 32'd1, 32'd2, 3'd0); req_valid = 4'b0001; rsp_ready = 1'b1; step();
        set_req(1, 32'hF0, 32'h0F, 3'd3); req_valid = 4'b0010; rsp_ready = 1'b0;
        repeat (3) step();
        rsp_ready = 1'b1; step();
        req_valid = 4'b0000; step();

        // Shift boundary cases
        set_req(0, 32'h8000_0000, 32'd4, 3'd7); req_valid = 4'b0001; step();
        set_req(0, 32'h8000_0000, 32'd32, 3'd5); step();
        set_req(0, 32'h8000_0000, 32'd31, 3'd6); step();
        set_req(0, 32'h8000_0000, 32'd40, 3'd7); step();
        set_req(0, 32'h8000_0000, 32'd33, 3'd6); step();
        req_valid = 4'b0000; step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                        3'($urandom_range(0, 7)));
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Reset while FULL with pending requests
        set_req(0, 32'd9, 32'd1, 3'd0); req_valid = 4'b0001; rsp_ready = 1'b1; step();
        req_valid = 4'b1010; rsp_ready = 1'b0; step();
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_ops_done", 64'(ops_done), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        step();
        step();
        req_valid = 4'b0000; step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
